// File: rtl/temp_pkg.sv
// temp_pkg: shared field layout, FSM state type and bucket-aging rule for the
// time-sliced Bloom filter line. Both the write-side updater and the read-side
// query engine call calc_shifts so their aging can never disagree.
package temp_pkg;
    localparam int DATA_WIDTH     = 72;
    localparam int NUM_BUCKETS    = 14;
    localparam int BUCKET_SZ      = 4;
    localparam int BITS_SHIFT     = 4;
    localparam int BLOOM_INIT_POS = 16;
    localparam int ADDR_WIDTH     = 19;
    localparam int BIT_IDX_W      = 2;
    localparam int TIMEOUT        = 64;
    localparam int LOOP_W         = BLOOM_INIT_POS - BITS_SHIFT;
    localparam int BLOOM_W        = NUM_BUCKETS * BUCKET_SZ;
    // one extra bit so out-of-range shift values stay distinguishable from 0..14
    localparam int SHIFT_W        = 5;
    localparam int TMO_W          = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, EVAL, RESP} state_t;

    function automatic logic [LOOP_W-1:0] get_loop(input logic [DATA_WIDTH-1:0] line);
        return line[LOOP_W-1:0];
    endfunction

    function automatic logic [BITS_SHIFT-1:0] get_bucket(input logic [DATA_WIDTH-1:0] line);
        return line[BLOOM_INIT_POS-1:LOOP_W];
    endfunction

    function automatic logic [BLOOM_W-1:0] get_bloom(input logic [DATA_WIDTH-1:0] line);
        return line[BLOOM_INIT_POS +: BLOOM_W];
    endfunction

    // Number of oldest buckets that have expired since the line was last written.
    function automatic logic [SHIFT_W-1:0] calc_shifts(
        input logic [LOOP_W-1:0]     dl,
        input logic [BITS_SHIFT-1:0] db,
        input logic [LOOP_W-1:0]     cl,
        input logic [BITS_SHIFT-1:0] cb
    );
        logic [SHIFT_W-1:0] nb;
        logic [SHIFT_W-1:0] wrapd;
        logic [LOOP_W:0]    gap;
        nb    = SHIFT_W'(NUM_BUCKETS);
        wrapd = nb - {1'b0, db} + {1'b0, cb};
        // loop counter wrapped: only a distance of exactly one loop keeps buckets alive
        gap   = {1'b1, cl} - {1'b0, dl};
        return (cl == dl) ? ((cb >= db) ? SHIFT_W'(cb - db) : '0) :
               (cl > dl)  ? ((cb < db) ? wrapd : nb) :
               ((gap > (LOOP_W+1)'(1)) ? nb : wrapd);
    endfunction
endpackage

// File: rtl/conta_bucket.sv
// conta_bucket: counts live buckets whose selected bit is set.
//   bloom   in  bloom field of the line, bucket i at [i*BUCKET_SZ +: BUCKET_SZ]
//   shifts  in  buckets below this index are expired (>= NUM_BUCKETS: all)
//   bit_idx in  bit position inside each bucket
//   cnt     out number of live buckets with that bit set
module conta_bucket
    import temp_pkg::*;
(
    input  logic [BLOOM_W-1:0]    bloom,
    input  logic [SHIFT_W-1:0]    shifts,
    input  logic [BIT_IDX_W-1:0]  bit_idx,
    output logic [BITS_SHIFT-1:0] cnt
);
    logic [BUCKET_SZ-1:0] b;

    always_comb begin
        cnt = '0;
        b   = '0;
        for (int i = 0; i < NUM_BUCKETS; i++) begin
            b   = bloom[i*BUCKET_SZ +: BUCKET_SZ];
            cnt = cnt + BITS_SHIFT'((SHIFT_W'(i) >= shifts) && b[bit_idx]);
        end
    end
endmodule

// File: rtl/consulta_linha.sv
// consulta_linha: read-only membership query against one time-sliced Bloom line.
//   query_*      in/out  query handshake; query_rdy high only when idle
//   cur_bucket/cur_loop  current time, sampled when the query is accepted
//   sram_rd_*    in/out  read port: req held until ack, data on vld
//   result_*     in/out  result handshake; hit/cnt from live buckets, err on timeout
module consulta_linha
    import temp_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  query_vld,
    output logic                  query_rdy,
    input  logic [ADDR_WIDTH-1:0] query_addr,
    input  logic [BIT_IDX_W-1:0]  query_bit,
    input  logic [BITS_SHIFT-1:0] cur_bucket,
    input  logic [LOOP_W-1:0]     cur_loop,
    output logic                  sram_rd_req,
    output logic [ADDR_WIDTH-1:0] sram_rd_addr,
    input  logic                  sram_rd_ack,
    input  logic                  sram_rd_vld,
    input  logic [DATA_WIDTH-1:0] sram_rd_data,
    output logic                  result_vld,
    input  logic                  result_rdy,
    output logic                  result_hit,
    output logic [BITS_SHIFT-1:0] result_cnt,
    output logic                  result_err
);
    state_t                state;
    logic [BIT_IDX_W-1:0]  bit_q;
    logic [BITS_SHIFT-1:0] cb_q;
    logic [LOOP_W-1:0]     cl_q;
    logic [DATA_WIDTH-1:0] line_q;
    logic [TMO_W-1:0]      tmo;
    logic [SHIFT_W-1:0]    shifts;
    logic [BITS_SHIFT-1:0] live_cnt;
    logic                  timed_out;

    assign query_rdy   = state == IDLE;
    assign sram_rd_req = state == REQ;
    assign result_vld  = state == RESP;
    assign timed_out   = tmo >= TMO_W'(TIMEOUT - 1);
    assign shifts      = calc_shifts(get_loop(line_q), get_bucket(line_q), cl_q, cb_q);

    conta_bucket u_conta (
        .bloom   (get_bloom(line_q)),
        .shifts  (shifts),
        .bit_idx (bit_q),
        .cnt     (live_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            sram_rd_addr <= '0;
            bit_q        <= '0;
            cb_q         <= '0;
            cl_q         <= '0;
            line_q       <= '0;
            tmo          <= '0;
            result_hit   <= 1'b0;
            result_cnt   <= '0;
            result_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (query_vld) begin
                    sram_rd_addr <= query_addr;
                    bit_q        <= query_bit;
                    cb_q         <= cur_bucket;
                    cl_q         <= cur_loop;
                    tmo          <= '0;
                    state        <= REQ;
                end
                REQ: begin
                    tmo <= tmo + 1'b1;
                    // data arriving with the grant wins over an expiring timer
                    if (sram_rd_ack && sram_rd_vld) begin
                        line_q <= sram_rd_data;
                        state  <= EVAL;
                    end else if (timed_out) begin
                        result_hit <= 1'b0;
                        result_cnt <= '0;
                        result_err <= 1'b1;
                        state      <= RESP;
                    end else if (sram_rd_ack) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    tmo <= tmo + 1'b1;
                    if (sram_rd_vld) begin
                        line_q <= sram_rd_data;
                        state  <= EVAL;
                    end else if (timed_out) begin
                        result_hit <= 1'b0;
                        result_cnt <= '0;
                        result_err <= 1'b1;
                        state      <= RESP;
                    end
                end
                EVAL: begin
                    result_hit <= live_cnt != '0;
                    result_cnt <= live_cnt;
                    result_err <= 1'b0;
                    state      <= RESP;
                end
                RESP: if (result_rdy) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_consulta_linha.sv
// tb_consulta_linha: directed vector bench for consulta_linha and conta_bucket.
module tb_consulta_linha;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        query_vld = 1'b0;
    logic        query_rdy;
    logic [18:0] query_addr = '0;
    logic [1:0]  query_bit = '0;
    logic [3:0]  cur_bucket = '0;
    logic [11:0] cur_loop = '0;
    logic        sram_rd_req;
    logic [18:0] sram_rd_addr;
    logic        sram_rd_ack = 1'b0;
    logic        sram_rd_vld = 1'b0;
    logic [71:0] sram_rd_data = '0;
    logic        result_vld;
    logic        result_rdy = 1'b0;
    logic        result_hit;
    logic [3:0]  result_cnt;
    logic        result_err;

    logic [55:0] cb_bloom = '0;
    logic [4:0]  cb_shifts = '0;
    logic [1:0]  cb_bit = '0;
    logic [3:0]  cb_cnt;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    consulta_linha dut (
        .clk(clk), .reset(reset),
        .query_vld(query_vld), .query_rdy(query_rdy), .query_addr(query_addr),
        .query_bit(query_bit), .cur_bucket(cur_bucket), .cur_loop(cur_loop),
        .sram_rd_req(sram_rd_req), .sram_rd_addr(sram_rd_addr), .sram_rd_ack(sram_rd_ack),
        .sram_rd_vld(sram_rd_vld), .sram_rd_data(sram_rd_data),
        .result_vld(result_vld), .result_rdy(result_rdy), .result_hit(result_hit),
        .result_cnt(result_cnt), .result_err(result_err)
    );

    conta_bucket u_cb (.bloom(cb_bloom), .shifts(cb_shifts), .bit_idx(cb_bit), .cnt(cb_cnt));

    typedef struct {
        logic [11:0] dl;
        logic [3:0]  db;
        logic [55:0] bloom;
        logic [11:0] cl;
        logic [3:0]  cb;
        logic [1:0]  bi;
        int          ack_dly;
        int          vld_dly;
        logic        hit;
        logic [3:0]  cnt;
    } vec_t;

    localparam logic [55:0] B1   = 56'h10000000000001;
    localparam logic [55:0] B2   = 56'h00110000000000;
    localparam logic [55:0] B3   = 56'h20202020202020;
    localparam logic [55:0] ONES = {56{1'b1}};

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_query(input logic [71:0] line, input logic [18:0] addr, input logic [11:0] cl,
                            input logic [3:0] cb, input logic [1:0] bi,
                            input int ack_dly, input int vld_dly, output int lat);
        @(negedge clk);
        query_vld = 1'b1; query_addr = addr; query_bit = bi; cur_loop = cl; cur_bucket = cb;
        @(negedge clk);
        query_vld = 1'b0; query_addr = '0; query_bit = '0; cur_loop = '0; cur_bucket = '0;
        chk("req_after_accept", sram_rd_req, 1);
        chk("rd_addr", sram_rd_addr, addr);
        repeat (ack_dly) @(negedge clk);
        if (vld_dly == 0) begin
            sram_rd_ack = 1'b1; sram_rd_vld = 1'b1; sram_rd_data = line;
            @(negedge clk);
            sram_rd_ack = 1'b0; sram_rd_vld = 1'b0; sram_rd_data = '0;
        end else begin
            sram_rd_ack = 1'b1;
            @(negedge clk);
            sram_rd_ack = 1'b0;
            repeat (vld_dly - 1) @(negedge clk);
            sram_rd_vld = 1'b1; sram_rd_data = line;
            @(negedge clk);
            sram_rd_vld = 1'b0; sram_rd_data = '0;
        end
        lat = 1;
        while (!result_vld && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pop();
        result_rdy = 1'b1;
        @(negedge clk);
        result_rdy = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int k;
        logic ok;
        vecs[0] = '{12'h005, 4'd3, B1,   12'h005, 4'd4,  2'd0, 0, 0, 1'b1, 4'd1};
        vecs[1] = '{12'h005, 4'd3, B1,   12'h006, 4'd3,  2'd0, 2, 0, 1'b0, 4'd0};
        vecs[2] = '{12'h005, 4'd3, B1,   12'h006, 4'd2,  2'd0, 1, 3, 1'b1, 4'd1};
        vecs[3] = '{12'hFFF, 4'd5, B2,   12'h000, 4'd2,  2'd0, 0, 2, 1'b1, 4'd1};
        vecs[4] = '{12'hFFF, 4'd5, B2,   12'h001, 4'd2,  2'd0, 3, 1, 1'b0, 4'd0};
        vecs[5] = '{12'h005, 4'd3, ONES, 12'h005, 4'd3,  2'd2, 0, 0, 1'b1, 4'd14};
        vecs[6] = '{12'h005, 4'd3, ONES, 12'h005, 4'd2,  2'd1, 0, 1, 1'b1, 4'd14};
        vecs[7] = '{12'h005, 4'd3, ONES, 12'h005, 4'd10, 2'd3, 2, 2, 1'b1, 4'd7};
        vecs[8] = '{12'h005, 4'd3, B3,   12'h006, 4'd1,  2'd1, 0, 0, 1'b1, 4'd1};
        vecs[9] = '{12'h005, 4'd3, B3,   12'h006, 4'd1,  2'd0, 1, 1, 1'b0, 4'd0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_query_rdy", query_rdy, 1);
        chk("rst_req", sram_rd_req, 0);
        chk("rst_result_vld", result_vld, 0);
        chk("rst_hit", result_hit, 0);
        chk("rst_cnt", result_cnt, 0);
        chk("rst_err", result_err, 0);
        chk("rst_addr", sram_rd_addr, 0);

        cb_bloom = ONES; cb_shifts = 5'd0;  cb_bit = 2'd0; #1 chk("cb_all_live", cb_cnt, 14);
        cb_shifts = 5'd13;                                 #1 chk("cb_one_live", cb_cnt, 1);
        cb_shifts = 5'd14;                                 #1 chk("cb_none_live", cb_cnt, 0);
        cb_shifts = 5'd20;                                 #1 chk("cb_over", cb_cnt, 0);
        cb_bloom = B3; cb_shifts = 5'd0; cb_bit = 2'd1;    #1 chk("cb_odd", cb_cnt, 7);

        for (int i = 0; i < 10; i++) begin
            do_query({vecs[i].bloom, vecs[i].db, vecs[i].dl}, 19'h01000 + 19'(i * 'h111),
                     vecs[i].cl, vecs[i].cb, vecs[i].bi, vecs[i].ack_dly, vecs[i].vld_dly, lat);
            chk($sformatf("v%0d_latency", i), lat, 2);
            chk($sformatf("v%0d_hit", i), result_hit, vecs[i].hit);
            chk($sformatf("v%0d_cnt", i), result_cnt, vecs[i].cnt);
            chk($sformatf("v%0d_err", i), result_err, 0);
            pop();
        end

        // backpressure: result held stable while consumer stalls
        do_query({B1, 4'd3, 12'h005}, 19'h7ABCD, 12'h005, 4'd4, 2'd0, 0, 0, lat);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ok &= result_vld && result_hit && result_cnt == 4'd1 && !result_err && !query_rdy;
        end
        chk("bp_stable", ok, 1);
        result_rdy = 1'b1;
        @(negedge clk);
        result_rdy = 1'b0;
        chk("bp_rdy_back", query_rdy, 1);
        chk("bp_vld_drop", result_vld, 0);

        // timeout: no ack ever
        @(negedge clk);
        query_vld = 1'b1; query_addr = 19'h00042;
        @(negedge clk);
        query_vld = 1'b0;
        k = 1;
        while (!result_vld && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("tmo_latency", k, 65);
        chk("tmo_err", result_err, 1);
        chk("tmo_hit", result_hit, 0);
        chk("tmo_cnt", result_cnt, 0);
        chk("tmo_req_low", sram_rd_req, 0);
        pop();
        sram_rd_vld = 1'b1; sram_rd_data = {ONES, 16'h0};
        @(negedge clk);
        sram_rd_vld = 1'b0; sram_rd_data = '0;
        ok = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ok |= result_vld;
        end
        chk("tmo_stray_vld", ok, 0);

        // reset while REQ: request drops the next cycle
        @(negedge clk);
        query_vld = 1'b1; query_addr = 19'h00123;
        @(negedge clk);
        query_vld = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_req_drop", sram_rd_req, 0);

        // reset while WAIT: query lost, late data ignored
        @(negedge clk);
        query_vld = 1'b1; query_addr = 19'h00456;
        @(negedge clk);
        query_vld = 1'b0;
        sram_rd_ack = 1'b1;
        @(negedge clk);
        sram_rd_ack = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstw_req", sram_rd_req, 0);
        chk("rstw_rdy", query_rdy, 1);
        sram_rd_vld = 1'b1; sram_rd_data = {ONES, 16'h0};
        @(negedge clk);
        sram_rd_vld = 1'b0; sram_rd_data = '0;
        ok = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ok |= result_vld;
        end
        chk("rstw_no_result", ok, 0);
        do_query({B1, 4'd3, 12'h005}, 19'h00789, 12'h006, 4'd2, 2'd0, 1, 1, lat);
        chk("rstw_next_lat", lat, 2);
        chk("rstw_next_hit", result_hit, 1);
        chk("rstw_next_cnt", result_cnt, 1);
        pop();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
